// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for a JK-based SR flop: synchronises and debounces set/clear requests,
// issues one-cycle S/R pulses, verifies Q feedback with bounded retries.
module sr_cmd_sequencer #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned SET_PRIORITY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict,
  output logic err
);

  localparam int unsigned CntW   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CntW-1:0]   CntLast  = CntW'(DEB_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic              SetWins  = (SET_PRIORITY != 0);

  typedef enum logic [1:0] {StIdle, StIssue, StCheck} state_e;

  // Bit 0 tracks the set request, bit 1 the clear request.
  logic [1:0]        raw;
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        deb_q, deb_d, rise;
  logic [CntW-1:0]   cnt_q [2];
  logic [CntW-1:0]   cnt_d [2];
  logic [1:0]        pend_q, pend_d, pend_clr;
  state_e            state_q, state_d;
  logic              tgt_q, tgt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              s_q, s_d, r_q, r_d;
  logic              conf_q, conf_d, err_q, err_d;
  logic              pick;

  assign raw = {clr_req, set_req};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = deb_d & ~deb_q;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    retry_d  = retry_q;
    s_d      = 1'b0;
    r_d      = 1'b0;
    conf_d   = 1'b0;
    err_d    = err_q;
    pend_clr = 2'b00;
    pick     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q != 2'b00) begin
          conf_d = &pend_q;
          pick   = (&pend_q) ? SetWins : pend_q[0];
          if (&pend_q) begin
            if (pick) pend_clr[1] = 1'b1;
            else      pend_clr[0] = 1'b1;
          end
          // Flop already holds the requested value: retire the request silently.
          if (pick == q_fb) begin
            if (pick) pend_clr[0] = 1'b1;
            else      pend_clr[1] = 1'b1;
          end else begin
            tgt_d   = pick;
            retry_d = '0;
            state_d = StIssue;
            s_d     = pick;
            r_d     = ~pick;
          end
        end
      end
      StIssue: state_d = StCheck;
      StCheck: begin
        if (q_fb == tgt_q || retry_q == RetryMax) begin
          if (q_fb != tgt_q) err_d = 1'b1;
          if (tgt_q) pend_clr[0] = 1'b1;
          else       pend_clr[1] = 1'b1;
          state_d = StIdle;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = StIssue;
          s_d     = tgt_q;
          r_d     = ~tgt_q;
        end
      end
      default: state_d = StIdle;
    endcase
    // A fresh rising edge re-arms the flag even if it is being retired this cycle.
    pend_d = (pend_q & ~pend_clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '{default: '0};
      pend_q  <= '0;
      state_q <= StIdle;
      tgt_q   <= 1'b0;
      retry_q <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      conf_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      s_q     <= s_d;
      r_q     <= r_d;
      conf_q  <= conf_d;
      err_q   <= err_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign busy     = (state_q != StIdle);
  assign conflict = conf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer: default instance plus a clear-priority instance,
// each closing the loop through a behavioural SR flop.
module tb_sr_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0, clr_req = 1'b0;
  logic set_b = 1'b0, clr_b = 1'b0;
  logic q_m = 1'b0, q_mb = 1'b1;
  logic q_force = 1'b0;
  logic q_fb, q_fb_b;
  logic S, R, busy, conflict, err;
  logic S_b, R_b, busy_b, conflict_b, err_b;

  int n_tests = 0;
  int n_fail  = 0;
  int s_cnt   = 0;
  int r_cnt   = 0;

  always #5 clk = ~clk;

  assign q_fb   = q_force ? 1'b0 : q_m;
  assign q_fb_b = q_mb;

  always @(posedge clk) begin
    if (S) q_m <= 1'b1;
    else if (R) q_m <= 1'b0;
    if (S_b) q_mb <= 1'b1;
    else if (R_b) q_mb <= 1'b0;
  end

  sr_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
    .S(S), .R(R), .busy(busy), .conflict(conflict), .err(err)
  );

  sr_cmd_sequencer #(.SET_PRIORITY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .set_req(set_b), .clr_req(clr_b), .q_fb(q_fb_b),
    .S(S_b), .R(R_b), .busy(busy_b), .conflict(conflict_b), .err(err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      s_cnt += int'(S);
      r_cnt += int'(R);
      check_eq("s_and_r", 32'(S & R), 0);
      check_eq("s_and_r_b", 32'(S_b & R_b), 0);
    end
  endtask

  initial begin
    tick(2);
    check_eq("rst_outs", 32'({S, R, busy, conflict, err}), 0);
    rst_n = 1'b1;
    tick(1);

    // Basic set: S at E7, CHECK sees Q=1, busy through E8.
    s_cnt = 0; r_cnt = 0;
    set_req = 1'b1;
    tick(6);
    check_eq("t1_s_e6", 32'(S), 0);
    check_eq("t1_busy_e6", 32'(busy), 0);
    tick(1);
    check_eq("t1_s_e7", 32'(S), 1);
    check_eq("t1_busy_e7", 32'(busy), 1);
    tick(1);
    check_eq("t1_s_e8", 32'(S), 0);
    check_eq("t1_busy_e8", 32'(busy), 1);
    check_eq("t1_qfb_check", 32'(q_fb), 1);
    tick(1);
    check_eq("t1_busy_e9", 32'(busy), 0);
    check_eq("t1_err", 32'(err), 0);
    set_req = 1'b0;
    tick(8);
    check_eq("t1_s_cnt", 32'(s_cnt), 1);
    check_eq("t1_r_cnt", 32'(r_cnt), 0);

    // Clear bounce of 3 synchronised cycles is rejected, then a stable clear.
    r_cnt = 0;
    clr_req = 1'b1;
    tick(3);
    clr_req = 1'b0;
    tick(10);
    check_eq("t2_bounce_r", 32'(r_cnt), 0);
    check_eq("t2_bounce_busy", 32'(busy), 0);
    clr_req = 1'b1;
    tick(6);
    check_eq("t2_r_e6", 32'(R), 0);
    tick(1);
    check_eq("t2_r_e7", 32'(R), 1);
    tick(1);
    check_eq("t2_r_e8", 32'(R), 0);
    check_eq("t2_qfb", 32'(q_fb), 0);
    tick(2);
    clr_req = 1'b0;
    tick(8);
    check_eq("t2_r_cnt", 32'(r_cnt), 1);

    // Simultaneous requests, set priority, Q=0.
    s_cnt = 0; r_cnt = 0;
    set_req = 1'b1; clr_req = 1'b1;
    tick(6);
    check_eq("t3_conf_e6", 32'(conflict), 0);
    tick(1);
    check_eq("t3_conf_e7", 32'(conflict), 1);
    check_eq("t3_s_e7", 32'(S), 1);
    tick(1);
    check_eq("t3_conf_e8", 32'(conflict), 0);
    check_eq("t3_qfb", 32'(q_fb), 1);
    tick(6);
    set_req = 1'b0; clr_req = 1'b0;
    tick(8);
    check_eq("t3_s_cnt", 32'(s_cnt), 1);
    check_eq("t3_r_cnt", 32'(r_cnt), 0);

    // Simultaneous requests, clear priority, Q=1.
    set_b = 1'b1; clr_b = 1'b1;
    tick(7);
    check_eq("t3b_conf", 32'(conflict_b), 1);
    check_eq("t3b_r", 32'(R_b), 1);
    check_eq("t3b_s", 32'(S_b), 0);
    tick(1);
    check_eq("t3b_r_off", 32'(R_b), 0);
    check_eq("t3b_q", 32'(q_fb_b), 0);
    tick(6);
    check_eq("t3b_busy", 32'(busy_b), 0);
    check_eq("t3b_s_never", 32'(S_b), 0);
    set_b = 1'b0; clr_b = 1'b0;
    tick(8);

    // Q stuck at 0: three pulses, then sticky err.
    q_force = 1'b1;
    s_cnt = 0;
    set_req = 1'b1;
    tick(7);
    check_eq("t4_p1", 32'(S), 1);
    tick(1);
    check_eq("t4_chk1", 32'(S), 0);
    tick(1);
    check_eq("t4_p2", 32'(S), 1);
    tick(1);
    check_eq("t4_chk2", 32'(S), 0);
    tick(1);
    check_eq("t4_p3", 32'(S), 1);
    tick(1);
    check_eq("t4_err_chk3", 32'(err), 0);
    check_eq("t4_busy_chk3", 32'(busy), 1);
    tick(1);
    check_eq("t4_err", 32'(err), 1);
    check_eq("t4_busy_done", 32'(busy), 0);
    set_req = 1'b0;
    tick(8);
    check_eq("t4_s_cnt", 32'(s_cnt), 3);
    check_eq("t4_err_sticky", 32'(err), 1);
    q_force = 1'b0;

    // Q already 1: set request retired without a pulse; later clear still served.
    s_cnt = 0; r_cnt = 0;
    set_req = 1'b1;
    tick(7);
    check_eq("t5_busy_e7", 32'(busy), 0);
    tick(3);
    set_req = 1'b0;
    tick(8);
    check_eq("t5_no_s", 32'(s_cnt), 0);
    clr_req = 1'b1;
    tick(7);
    check_eq("t5_r_e7", 32'(R), 1);
    tick(1);
    check_eq("t5_qfb", 32'(q_fb), 0);
    clr_req = 1'b0;
    tick(10);
    check_eq("t5_r_cnt", 32'(r_cnt), 1);
    check_eq("t5_s_after", 32'(s_cnt), 0);
    check_eq("t5_err_kept", 32'(err), 1);

    // Reset asserted mid-ISSUE drops S immediately and nothing resumes.
    set_req = 1'b1;
    tick(7);
    check_eq("t6_s_issue", 32'(S), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_outs", 32'({S, R, busy, conflict, err}), 0);
    set_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    s_cnt = 0;
    tick(12);
    check_eq("t6_no_resume", 32'(s_cnt), 0);
    check_eq("t6_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_cmd_sequencer.md
Name: sr_cmd_sequencer

Overview:
- Upstream command stage for the SR flip-flop built from a JK core.
- Takes two raw, bouncy request inputs (set, clear) and synchronises and debounces them.
- Converts each debounced rising edge into a one-cycle S or R pulse. S and R are never high together, so the JK core never enters toggle.
- Checks the flop's Q feedback after each pulse, retries on mismatch, and flags a persistent failure.

Parameters:
- DEB_CYCLES, 4, consecutive stable synchronised cycles required before the debounced level changes (≥1).
- MAX_RETRY, 2, extra pulses issued after a failed Q check before giving up (≥0).
- SET_PRIORITY, 1, 1 = set wins when both requests are pending; 0 = clear wins.

Ports:
- clk  input  1  rising-edge clock, shared with the SR flop.
- rst_n  input  1  asynchronous, active-low reset.
- set_req  input  1  raw asynchronous set request (button or level).
- clr_req  input  1  raw asynchronous clear request.
- q_fb  input  1  Q output of the downstream SR flop.
- S  output  1  registered set pulse to the SR flop.
- R  output  1  registered reset pulse to the SR flop.
- busy  output  1  high whenever the FSM is not IDLE.
- conflict  output  1  one-cycle pulse when both requests are pending in IDLE.
- err  output  1  sticky; set when retries are exhausted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - S, R, busy, conflict, err = 0; state = IDLE.
  - Synchroniser flops, debounced levels, debounce counters, pending flags and retry count all = 0.
  - Reset mid-pulse drops S/R immediately; no pulse resumes after release.
- Synchroniser: 2 flops per input; s_set/s_clr is valid after the 2nd edge.
- Debounce, per input:
  - Counter width is clog2(DEB_CYCLES+1).
  - If s == deb: cnt <= 0.
  - Otherwise, if cnt == DEB_CYCLES-1: deb <= s and cnt <= 0; else cnt++.
  - Any glitch shorter than DEB_CYCLES synchronised cycles produces no deb change.
- Request capture:
  - A deb 0->1 transition sets the pending flag on the same edge that deb updates.
  - A further rising edge while the flag is already pending merges (no queueing).
  - Falling edges are ignored.
- FSM states: IDLE, ISSUE, CHECK.
- IDLE:
  - Both pending: pulse conflict for 1 cycle. Pick the winner per SET_PRIORITY and clear the loser's pending flag.
  - If the chosen target already equals q_fb: clear its pending flag, stay IDLE, issue no pulse.
  - Otherwise: latch the target, retry <= 0, go to ISSUE. S (set) or R (clear) is registered high on this edge.
- ISSUE: lasts exactly 1 cycle; S/R high for exactly this cycle; next state CHECK with S=R=0.
- CHECK:
  - The flop captured S/R on the edge ending ISSUE, so q_fb now reflects it.
  - q_fb == target: clear that pending flag, go to IDLE.
  - Mismatch and retry < MAX_RETRY: retry++, go to ISSUE, re-assert the same pulse.
  - Mismatch and retry == MAX_RETRY: err <= 1, clear that pending flag, go to IDLE.
- Requests arriving while busy stay pending and are served on return to IDLE; the earliest service is the cycle after CHECK.
- Invariant: S & R == 0 at all times. At most 1+MAX_RETRY pulses per accepted request.
- Latency:
  - Raw input held high from the first sampling edge E1 (DEB_CYCLES=4): deb rises at E6 and pending is set at E6; the FSM leaves IDLE at E7.
  - S is high from E7 to E8; CHECK is the cycle after E8; busy is high from E7 to E9.
  - In general, S rises at edge DEB_CYCLES+3.
- err is sticky; only rst_n clears it. Later requests are still served normally.

Test Plan:
- Defaults, q_fb model = real SR flop, set_req held high from E1 -> S high for exactly 1 cycle starting E7, R=0 throughout, q_fb=1 in CHECK, busy high E7..E9, err=0.
- clr_req high for 3 synchronised cycles, then low (a bounce) -> no R pulse, pending stays 0; then held 10 cycles -> a single R pulse at E7 relative to the start of the stable period.
- set_req and clr_req rise on the same edge, Q=0, SET_PRIORITY=1 -> conflict is a 1-cycle pulse, only S pulses, R never asserts, Q=1. Repeat with SET_PRIORITY=0 and Q=1 -> only R pulses.
- q_fb tied 0, set request, MAX_RETRY=2 -> exactly 3 one-cycle S pulses, each separated by one CHECK cycle; err rises after the 3rd CHECK and stays high; busy returns to 0.
- Q already 1, set request -> no S pulse, busy stays 0, pending cleared; a subsequent clear request produces a normal R pulse.
- Assert rst_n=0 during the ISSUE cycle -> S drops to 0 asynchronously and all outputs are 0. After release, no pulse occurs until a new debounced edge. Also check S&R==0 on every cycle of every test.
